// File: rtl/lsu_writeback.sv
// Load/store unit: one memory access at a time, result written back through wr/wr_data.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned halfword/word accesses without a bus request.
`timescale 1ns/1ps
module lsu_writeback #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  wr,
    output logic [31:0] wr_data,
    output logic        done,
    output logic        fault
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t      state_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q;

    logic [1:0]  off_d;
    logic        reject_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_d;

    // Request decode: legality, optional alignment trap, store lane placement.
    always_comb begin
        off_d    = req_addr[1:0];
        reject_d = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: reject_d = 1'b0;
            3'b100, 3'b101:         reject_d = req_is_store;
            default:                reject_d = 1'b1;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01 && off_d[0])
            reject_d = 1'b1;
        if (req_funct3[1:0] == 2'b10 && off_d != 2'b00)
            reject_d = 1'b1;
`endif
        wstrb_d = '0;
        wdata_d = '0;
        if (req_is_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    wstrb_d = 4'b0001 << off_d;
                    wdata_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    wstrb_d = 4'b0011 << {off_d[1], 1'b0};
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: begin
                    wstrb_d = '1;
                    wdata_d = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_d = {24'd0, byte_sel};
            3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_d = {16'd0, half_sel};
            default: load_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wstrb     <= '0;
            mem_wdata     <= '0;
            wr            <= '0;
            wr_data       <= '0;
            done          <= 1'b0;
            fault         <= 1'b0;
            is_store_q    <= 1'b0;
            funct3_q      <= '0;
            off_q         <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        off_q      <= off_d;
                        rd_q       <= req_rd;
                        req_ready  <= 1'b0;
                        if (reject_d) begin
                            state_q <= WB;
                            done    <= 1'b1;
                            fault   <= 1'b1;
                        end else begin
                            state_q       <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_we        <= req_is_store;
                            mem_addr      <= {req_addr[31:2], 2'b00};
                            mem_wstrb     <= wstrb_d;
                            mem_wdata     <= wdata_d;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state_q       <= WAIT;
                        cnt_q         <= '0;
                        mem_req_valid <= 1'b0;
                        mem_we        <= 1'b0;
                        mem_addr      <= '0;
                        mem_wstrb     <= '0;
                        mem_wdata     <= '0;
                    end
                end
                WAIT: begin
                    // A response in the final counted cycle still wins over the timeout.
                    if (mem_rsp_valid) begin
                        state_q <= WB;
                        done    <= 1'b1;
                        if (!is_store_q) begin
                            wr      <= rd_q;
                            wr_data <= load_d;
                        end
                    end else if (cnt_q == TIMEOUT_W) begin
                        state_q <= WB;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WB: begin
                    state_q   <= IDLE;
                    req_ready <= 1'b1;
                    done      <= 1'b0;
                    fault     <= 1'b0;
                    wr        <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_writeback.sv
// Randomized bench for lsu_writeback: per-cycle expectations from a transaction-level model.
`timescale 1ns/1ps
module tb_lsu_writeback;

    localparam int unsigned T = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [4:0]  wr;
    logic [31:0] wr_data;
    logic        done, fault;

    lsu_writeback #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wr(wr), .wr_data(wr_data), .done(done), .fault(fault)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    logic        chk_en = 1'b0;
    logic        saw_mvalid = 1'b0;
    logic        e_ready, e_mvalid, e_we, e_chk_mwd, e_done, e_fault, e_chk_wrd;
    logic [31:0] e_addr, e_mwd, e_wrd;
    logic [3:0]  e_strb;
    logic [4:0]  e_wr;

    logic [31:0] l_maddr, l_mwdata, l_wrd;
    logic [3:0]  l_strb;
    logic        l_we, l_done, l_fault;
    logic [4:0]  l_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the unit's decisions, from the instruction semantics.
    function automatic logic m_reject(input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        if (st) bad = !(f3 inside {3'd0, 3'd1, 3'd2});
        else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (TRAP && (f3 % 4) == 1 && (off % 2) == 1) bad = 1'b1;
        if (TRAP && (f3 % 4) == 2 && off != 0) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] m_strb(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (!st) return 4'd0;
        if (f3 % 4 == 0) return 4'(1 << off);
        if (f3 % 4 == 1) return 4'(3 << ((off / 2) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_mwdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 % 4 == 0) return (wd & 32'd255) * 32'h0101_0101;
        if (f3 % 4 == 1) return (wd & 32'd65535) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_extract(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int off;
        logic [31:0] v;
        off = int'(a % 4);
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * off)) & 32'd255;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rd >> (16 * (off / 2))) & 32'd65535;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (mem_req_valid) saw_mvalid = 1'b1;
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("mem_req_valid", 32'(mem_req_valid), 32'(e_mvalid));
            chk("done", 32'(done), 32'(e_done));
            chk("fault", 32'(fault), 32'(e_fault));
            chk("wr", 32'(wr), 32'(e_wr));
            if (e_mvalid) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
                if (e_chk_mwd) chk("mem_wdata", mem_wdata, e_mwd);
            end
            if (e_chk_wrd) chk("wr_data", wr_data, e_wrd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_ready = 1'b1; e_mvalid = 1'b0; e_done = 1'b0; e_fault = 1'b0;
        e_wr = '0; e_chk_wrd = 1'b0; e_chk_mwd = 1'b0;
    endtask

    task automatic set_busy();
        set_idle();
        e_ready = 1'b0;
    endtask

    task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        set_busy();
        e_mvalid = 1'b1; e_we = st; e_addr = {a[31:2], 2'b00};
        e_strb = m_strb(st, f3, a); e_mwd = m_mwdata(f3, wd); e_chk_mwd = st;
    endtask

    task automatic record_wb();
        l_done = done; l_fault = fault; l_wr = wr; l_wrd = wr_data;
    endtask

    // sdly: WAIT cycle index carrying the response, or -1 for none.
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input int rdly, input int sdly, input logic [31:0] rdata);
        logic tmo;
        set_idle();
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        mem_req_ready = 1'($urandom % 2); mem_rsp_valid = 1'($urandom % 2); mem_rdata = $urandom;
        step();
        req_valid = 1'b0; req_is_store = 1'($urandom % 2); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        if (m_reject(st, f3, a[1:0])) begin
            set_busy();
            e_done = 1'b1; e_fault = 1'b1;
            mem_req_ready = 1'b0; mem_rsp_valid = 1'($urandom % 2);
            record_wb();
            step();
            set_idle();
            mem_rsp_valid = 1'b0;
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            set_req(st, f3, a, wd);
            mem_req_ready = (i == rdly);
            mem_rsp_valid = 1'($urandom % 2); mem_rdata = $urandom;
            if (i == rdly) begin
                l_maddr = mem_addr; l_mwdata = mem_wdata; l_strb = mem_wstrb; l_we = mem_we;
            end
            step();
        end
        mem_req_ready = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i <= int'(T); i++) begin
            set_busy();
            if (i == sdly) begin
                mem_rsp_valid = 1'b1; mem_rdata = rdata; tmo = 1'b0;
            end else begin
                mem_rsp_valid = 1'b0; mem_rdata = $urandom;
            end
            step();
            if (!tmo) break;
        end
        set_busy();
        e_done = 1'b1; e_fault = tmo;
        e_wr = (!st && !tmo) ? rd : 5'd0;
        e_chk_wrd = !st && !tmo && rd != 5'd0;
        e_wrd = m_extract(f3, a, rdata);
        mem_rsp_valid = 1'($urandom % 2); mem_rdata = $urandom;
        record_wb();
        step();
        set_idle();
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0; req_rd = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        set_idle();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_wr", 32'(wr), 32'd0);
        chk("reset_wr_data", wr_data, 32'd0);
        chk("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
        step(); step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        do_txn(1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF_0000);
        chk("LB_wr", 32'(l_wr), 32'd5);
        chk("LB_wr_data", l_wrd, 32'hFFFF_FF80);
        chk("LB_done", 32'(l_done), 32'd1);
        chk("LB_fault", 32'(l_fault), 32'd0);

        do_txn(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 0, 1, 32'h0);
        chk("SH_mem_addr", l_maddr, 32'h200);
        chk("SH_mem_wdata", l_mwdata, 32'hABCD_ABCD);
        chk("SH_mem_wstrb", 32'(l_strb), 32'hC);
        chk("SH_mem_we", 32'(l_we), 32'd1);
        chk("SH_wr", 32'(l_wr), 32'd0);

        do_txn(1'b0, 3'b010, 32'h300, 32'h0, 5'd12, 3, 2, 32'hCAFE_F00D);
        chk("LW_stall_wr_data", l_wrd, 32'hCAFE_F00D);
        chk("LW_stall_wr", 32'(l_wr), 32'd12);

        do_txn(1'b0, 3'b010, 32'h400, 32'h0, 5'd8, 0, -1, 32'h0);
        chk("TMO_done", 32'(l_done), 32'd1);
        chk("TMO_fault", 32'(l_fault), 32'd1);
        chk("TMO_wr", 32'(l_wr), 32'd0);

        saw_mvalid = 1'b0;
        do_txn(1'b0, 3'b001, 32'h101, 32'h0, 5'd7, 1, 0, 32'h1234_8765);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("LH_mis_fault", 32'(l_fault), 32'd1);
        chk("LH_mis_no_mem_req", 32'(saw_mvalid), 32'd0);
        chk("LH_mis_wr", 32'(l_wr), 32'd0);
`else
        chk("LH_101_wr_data", l_wrd, 32'hFFFF_8765);
        chk("LH_101_fault", 32'(l_fault), 32'd0);
        chk("LH_101_wr", 32'(l_wr), 32'd7);
`endif

        do_txn(1'b1, 3'b100, 32'h500, 32'h55, 5'd4, 0, 0, 32'h0);
        chk("SBU_illegal_fault", 32'(l_fault), 32'd1);
        chk("SBU_illegal_wr", 32'(l_wr), 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic       st;
            logic [2:0] f3;
            int         sd;
            st = 1'($urandom % 2);
            f3 = 3'($urandom);
            if (st && ($urandom % 4) != 0) f3 = 3'($urandom % 3);
            sd = (($urandom % 8) == 0) ? -1 : int'($urandom_range(T, 0));
            do_txn(st, f3, $urandom, $urandom, 5'($urandom), int'($urandom % 4), sd, $urandom);
            repeat ($urandom % 3) begin
                set_idle();
                mem_rsp_valid = 1'($urandom % 2);
                step();
            end
            mem_rsp_valid = 1'b0;
        end

        // Reset while REQ is stalled, then while in WAIT.
        set_idle();
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_rd = 5'd9;
        step();
        req_valid = 1'b0;
        set_req(1'b0, 3'b010, 32'h40, 32'h0);
        mem_req_ready = 1'b0;
        step(); step();
        rst_n = 1'b0;
        set_idle();
        #1;
        chk("rst_in_req_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_in_req_req_ready", 32'(req_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        set_req(1'b0, 3'b010, 32'h40, 32'h0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        set_busy();
        step();
        rst_n = 1'b0;
        set_idle();
        #1;
        chk("rst_in_wait_req_ready", 32'(req_ready), 32'd1);
        chk("rst_in_wait_mem_req_valid", 32'(mem_req_valid), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            mem_rsp_valid = 1'b1; mem_rdata = $urandom;
            step();
        end
        mem_rsp_valid = 1'b0;
        chk("rst_late_rsp_no_done", 32'(done), 32'd0);
        chk("rst_late_rsp_no_write", 32'(wr), 32'd0);
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
